// File: rtl/ddaeval_blk_pkg.sv
// ============================================================================
//  Module      : ddaeval_blk_pkg
//  Description : Shared constants, block address type and FSM encodings for
//                the DDA-eval block manager.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddaeval_blk_pkg;

    localparam int NBLK_LOG2 = 9;
    localparam int NBLK      = 1 << NBLK_LOG2;

    typedef logic [NBLK_LOG2-1:0] blk_addr_t;

    typedef enum logic {
        WR_SCAN  = 1'b0,
        WR_READY = 1'b1
    } wr_state_e;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_READ = 2'd1,
        HS_ACK  = 2'd2
    } hist_state_e;

endpackage

`default_nettype wire

// File: rtl/ddaeval_block_history_ram.sv
// ============================================================================
//  Module      : ddaeval_block_history_ram
//  Description : Ring of completed block addresses, simple dual-port memory
//                with one write port and one registered read port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddaeval_block_history_ram
    import ddaeval_blk_pkg::*;
(
    input  logic      clk_i,
    input  logic      we_i,
    input  blk_addr_t waddr_i,
    input  blk_addr_t wdata_i,
    input  logic      re_i,
    input  blk_addr_t raddr_i,
    output blk_addr_t rdata_o
);

    blk_addr_t mem_q [NBLK];
    blk_addr_t rdata_q;

    // Write port: one entry per completed block.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; contents are plain RAM, so no reset here.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/ddaeval_block_manager.sv
// ============================================================================
//  Module      : ddaeval_block_manager
//  Description : Tracks the digitizer write block, keeps a history ring of
//                completed blocks and owns the per-block lock/reserve bits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddaeval_block_manager
    import ddaeval_blk_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 write_done_i,
    output logic [NBLK_LOG2-1:0] write_block_o,
    output logic                 write_ready_o,
    input  logic                 history_req_i,
    input  logic [NBLK_LOG2-1:0] nprev_i,
    output logic                 history_ack_o,
    output logic [NBLK_LOG2:0]   block_o,
    input  logic                 lock_strobe_i,
    input  logic                 lock_i,
    input  logic [NBLK_LOG2-1:0] lock_address_i,
    output logic                 lock_ack_o,
    input  logic                 free_strobe_i,
    input  logic [NBLK_LOG2-1:0] free_address_i,
    output logic                 free_ack_o,
    output logic [NBLK_LOG2:0]   nreserved_o
);

    // ---------------- state ----------------
    wr_state_e            wr_state_q;
    blk_addr_t            wr_blk_q;
    blk_addr_t            cand_q;
    blk_addr_t            wr_ptr_q;
    logic [NBLK_LOG2:0]   nwritten_q;
    logic                 wr_ready_q;

    hist_state_e          hs_q;
    logic                 inv_q;
    logic [NBLK_LOG2:0]   block_q;
    logic                 hack_q;

    logic [NBLK-1:0]      lk_q;
    logic [NBLK-1:0]      rs_q;
    logic [NBLK_LOG2:0]   nres_q;
    logic [NBLK_LOG2:0]   nres_d;
    logic                 lock_ack_q;
    logic                 free_ack_q;
    logic                 free_done_q;

    // ---------------- combinational helpers ----------------
    logic      wr_fire;
    logic      cand_usable;
    logic      hist_rd_en;
    blk_addr_t hist_raddr;
    logic      hist_invalid;
    blk_addr_t ram_rdata;
    logic      free_fire;
    logic      free_only;
    logic      same_addr;
    logic      lk_new_l;
    logic      rs_new_l;
    logic      occ_old_l;
    logic      occ_new_l;
    logic      occ_old_f;
    logic      occ_new_f;
    logic [1:0] cnt_inc;
    logic [1:0] cnt_dec;

    // A completion is only honoured while the writer holds a valid block.
    assign wr_fire = write_done_i && (wr_state_q == WR_READY);

    // A lock landing on the candidate in the same cycle must win over the scan.
    assign cand_usable = !lk_q[cand_q] && !rs_q[cand_q] &&
                         !(lock_strobe_i && lock_i && (lock_address_i == cand_q));

    assign hist_rd_en   = (hs_q == HS_IDLE) && history_req_i;
    assign hist_raddr   = wr_ptr_q - blk_addr_t'(1) - nprev_i;
    assign hist_invalid = ({1'b0, nprev_i} >= nwritten_q);

    // A held free level is serviced once; the requester must drop it to re-arm.
    assign free_fire = free_strobe_i && !free_ack_q && !free_done_q;
    assign same_addr = (lock_address_i == free_address_i);
    assign free_only = free_fire && !(lock_strobe_i && same_addr);

    ddaeval_block_history_ram u_hist_ram (
        .clk_i   (clk_i),
        .we_i    (wr_fire),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_blk_q),
        .re_i    (hist_rd_en),
        .raddr_i (hist_raddr),
        .rdata_o (ram_rdata)
    );

    // Next L/R of each touched block and the resulting occupancy delta.
    always_comb begin
        lk_new_l  = lock_i;
        rs_new_l  = lock_i | rs_q[lock_address_i];
        if (free_fire && same_addr) begin
            rs_new_l = 1'b0;
        end
        occ_old_l = lk_q[lock_address_i] | rs_q[lock_address_i];
        occ_new_l = lk_new_l | rs_new_l;
        occ_old_f = lk_q[free_address_i] | rs_q[free_address_i];
        occ_new_f = lk_q[free_address_i];
        cnt_inc   = 2'd0;
        cnt_dec   = 2'd0;
        if (lock_strobe_i) begin
            if (!occ_old_l && occ_new_l) cnt_inc = cnt_inc + 2'd1;
            if (occ_old_l && !occ_new_l) cnt_dec = cnt_dec + 2'd1;
        end
        if (free_only && occ_old_f && !occ_new_f) begin
            cnt_dec = cnt_dec + 2'd1;
        end
        nres_d = nres_q + {{(NBLK_LOG2-1){1'b0}}, cnt_inc}
                        - {{(NBLK_LOG2-1){1'b0}}, cnt_dec};
    end

    // Writer FSM: hold a block in READY, hunt for the next usable one in SCAN.
    // The candidate wraps modulo NBLK, so a full fruitless lap naturally
    // restarts from the same start point.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_state_q <= WR_READY;
            wr_blk_q   <= '0;
            cand_q     <= '0;
            wr_ready_q <= 1'b1;
            wr_ptr_q   <= '0;
            nwritten_q <= '0;
        end else begin
            case (wr_state_q)
                WR_READY: begin
                    if (write_done_i) begin
                        wr_state_q <= WR_SCAN;
                        wr_ready_q <= 1'b0;
                        cand_q     <= wr_blk_q + blk_addr_t'(1);
                        wr_ptr_q   <= wr_ptr_q + blk_addr_t'(1);
                        if (nwritten_q != (NBLK_LOG2+1)'(NBLK)) begin
                            nwritten_q <= nwritten_q + 1'b1;
                        end
                    end
                end
                WR_SCAN: begin
                    if (cand_usable) begin
                        wr_state_q <= WR_READY;
                        wr_ready_q <= 1'b1;
                        wr_blk_q   <= cand_q;
                    end else begin
                        cand_q <= cand_q + blk_addr_t'(1);
                    end
                end
                default: begin
                    wr_state_q <= WR_READY;
                    wr_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // History FSM: address the RAM in IDLE, capture data in READ, pulse in ACK.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hs_q    <= HS_IDLE;
            inv_q   <= 1'b0;
            block_q <= '0;
            hack_q  <= 1'b0;
        end else begin
            case (hs_q)
                HS_IDLE: begin
                    hack_q  <= 1'b0;
                    block_q <= '0;
                    if (history_req_i) begin
                        hs_q  <= HS_READ;
                        inv_q <= hist_invalid;
                    end
                end
                HS_READ: begin
                    hs_q    <= HS_ACK;
                    hack_q  <= 1'b1;
                    block_q <= {inv_q, ram_rdata};
                end
                HS_ACK: begin
                    hs_q    <= HS_IDLE;
                    hack_q  <= 1'b0;
                    block_q <= '0;
                end
                default: begin
                    hs_q    <= HS_IDLE;
                    hack_q  <= 1'b0;
                    block_q <= '0;
                end
            endcase
        end
    end

    // Reservation bitmaps, handshake acks and the running occupancy count.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lk_q        <= '0;
            rs_q        <= '0;
            nres_q      <= '0;
            lock_ack_q  <= 1'b0;
            free_ack_q  <= 1'b0;
            free_done_q <= 1'b0;
        end else begin
            lock_ack_q  <= lock_strobe_i;
            free_ack_q  <= free_fire;
            free_done_q <= free_strobe_i && (free_done_q || free_fire);
            nres_q      <= nres_d;
            if (lock_strobe_i) begin
                lk_q[lock_address_i] <= lk_new_l;
                rs_q[lock_address_i] <= rs_new_l;
            end
            if (free_only) begin
                rs_q[free_address_i] <= 1'b0;
            end
        end
    end

    assign write_block_o = wr_blk_q;
    assign write_ready_o = wr_ready_q;
    assign history_ack_o = hack_q;
    assign block_o       = block_q;
    assign lock_ack_o    = lock_ack_q;
    assign free_ack_o    = free_ack_q;
    assign nreserved_o   = nres_q;

endmodule

`default_nettype wire

// File: tb/tb_ddaeval_block_manager.sv
// ============================================================================
//  Module      : tb_ddaeval_block_manager
//  Description : Self-checking bench for ddaeval_block_manager with a
//                behavioural model of the block bitmaps and history.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ddaeval_block_manager;

    logic       clk_i          = 1'b0;
    logic       rst_n_i        = 1'b0;
    logic       write_done_i   = 1'b0;
    logic       history_req_i  = 1'b0;
    logic [8:0] nprev_i        = '0;
    logic       lock_strobe_i  = 1'b0;
    logic       lock_i         = 1'b0;
    logic [8:0] lock_address_i = '0;
    logic       free_strobe_i  = 1'b0;
    logic [8:0] free_address_i = '0;
    logic [8:0] write_block_o;
    logic       write_ready_o;
    logic       history_ack_o;
    logic [9:0] block_o;
    logic       lock_ack_o;
    logic       free_ack_o;
    logic [9:0] nreserved_o;

    int total = 0;
    int bad   = 0;

    // Model: per-block flags, list of completed blocks, current writer block.
    bit mL [512];
    bit mR [512];
    int hist [$];
    int exp_blk = 0;

    ddaeval_block_manager dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .write_done_i   (write_done_i),
        .write_block_o  (write_block_o),
        .write_ready_o  (write_ready_o),
        .history_req_i  (history_req_i),
        .nprev_i        (nprev_i),
        .history_ack_o  (history_ack_o),
        .block_o        (block_o),
        .lock_strobe_i  (lock_strobe_i),
        .lock_i         (lock_i),
        .lock_address_i (lock_address_i),
        .lock_ack_o     (lock_ack_o),
        .free_strobe_i  (free_strobe_i),
        .free_address_i (free_address_i),
        .free_ack_o     (free_ack_o),
        .nreserved_o    (nreserved_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 512; i++) n += (mL[i] || mR[i]) ? 1 : 0;
        return n;
    endfunction

    // Distance to the next usable block after b, or -1 if none.
    function automatic int m_next(int b);
        for (int k = 1; k <= 512; k++) begin
            if (!mL[(b + k) % 512] && !mR[(b + k) % 512]) return k;
        end
        return -1;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 512; i++) begin
            mL[i] = 1'b0;
            mR[i] = 1'b0;
        end
        hist.delete();
        exp_blk = 0;
    endfunction

    function automatic void m_push(int b);
        hist.push_back(b);
        if (hist.size() > 512) void'(hist.pop_front());
    endfunction

    task automatic do_done();
        int k;
        int cyc;
        k = m_next(exp_blk);
        m_push(exp_blk);
        write_done_i = 1'b1;
        tick();
        write_done_i = 1'b0;
        total++;
        if (write_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL done_scan_start: ready=%0b want 0", write_ready_o);
        end
        cyc = 0;
        while (write_ready_o !== 1'b1 && cyc < 1100) begin
            tick();
            cyc++;
        end
        if (k > 0) exp_blk = (exp_blk + k) % 512;
        total++;
        if (write_block_o !== 9'(exp_blk) || cyc != k) begin
            bad++;
            $display("FAIL done_next: blk=%0d cycles=%0d want blk=%0d cycles=%0d",
                     write_block_o, cyc, exp_blk, k);
        end
    endtask

    task automatic do_lock(int a, bit l);
        lock_address_i = 9'(a);
        lock_i         = l;
        lock_strobe_i  = 1'b1;
        tick();
        lock_strobe_i  = 1'b0;
        if (l) begin
            mL[a] = 1'b1;
            mR[a] = 1'b1;
        end else begin
            mL[a] = 1'b0;
        end
        total++;
        if (lock_ack_o !== 1'b1 || nreserved_o !== 10'(m_count())) begin
            bad++;
            $display("FAIL lock %0d/%0b: ack=%0b nres=%0d want ack=1 nres=%0d",
                     a, l, lock_ack_o, nreserved_o, m_count());
        end
        tick();
        total++;
        if (lock_ack_o !== 1'b0) begin
            bad++;
            $display("FAIL lock_ack_pulse: ack=%0b want 0", lock_ack_o);
        end
    endtask

    task automatic do_free(int a);
        int cyc = 0;
        free_address_i = 9'(a);
        free_strobe_i  = 1'b1;
        do begin
            tick();
            cyc++;
        end while (free_ack_o !== 1'b1 && cyc < 10);
        free_strobe_i = 1'b0;
        mR[a] = 1'b0;
        total++;
        if (free_ack_o !== 1'b1 || cyc != 1 || nreserved_o !== 10'(m_count())) begin
            bad++;
            $display("FAIL free %0d: ack=%0b cycles=%0d nres=%0d want ack=1 cycles=1 nres=%0d",
                     a, free_ack_o, cyc, nreserved_o, m_count());
        end
        tick();
    endtask

    task automatic check_hist(int n, string tag);
        logic [9:0] e;
        if (n >= hist.size()) begin
            total++;
            if (block_o[9] !== 1'b1) begin
                bad++;
                $display("FAIL %s nprev=%0d: invalid=%0b want 1", tag, n, block_o[9]);
            end
        end else begin
            e = {1'b0, 9'(hist[hist.size() - 1 - n])};
            total++;
            if (block_o !== e) begin
                bad++;
                $display("FAIL %s nprev=%0d: block=%h want %h", tag, n, block_o, e);
            end
        end
    endtask

    task automatic do_hist(int n);
        nprev_i       = 9'(n);
        history_req_i = 1'b1;
        tick();
        total++;
        if (history_ack_o !== 1'b0) begin
            bad++;
            $display("FAIL hist_early_ack: ack=%0b want 0", history_ack_o);
        end
        tick();
        history_req_i = 1'b0;
        total++;
        if (history_ack_o !== 1'b1) begin
            bad++;
            $display("FAIL hist_ack_latency: ack=%0b want 1", history_ack_o);
        end
        check_hist(n, "hist");
        tick();
    endtask

    task automatic test_reset();
        m_reset();
        rst_n_i = 1'b0;
        tick();
        tick();
        #2 rst_n_i = 1'b1;
        tick();
        total++;
        if (write_block_o !== 9'd0 || write_ready_o !== 1'b1 || history_ack_o !== 1'b0 ||
            block_o !== 10'd0 || lock_ack_o !== 1'b0 || free_ack_o !== 1'b0 ||
            nreserved_o !== 10'd0) begin
            bad++;
            $display("FAIL reset_values: blk=%0d rdy=%0b hack=%0b block=%h lack=%0b fack=%0b nres=%0d want 0 1 0 0 0 0 0",
                     write_block_o, write_ready_o, history_ack_o, block_o,
                     lock_ack_o, free_ack_o, nreserved_o);
        end
    endtask

    task automatic test_basic();
        repeat (3) do_done();
        total++;
        if (write_block_o !== 9'd3) begin
            bad++;
            $display("FAIL basic_third_block: blk=%0d want 3", write_block_o);
        end
        do_hist(2);
        do_hist(3);
        do_hist(0);
    endtask

    task automatic test_lock_skip();
        do_lock(5, 1'b1);
        do_done();
        do_done();
        total++;
        if (write_block_o !== 9'd6 || nreserved_o !== 10'd1) begin
            bad++;
            $display("FAIL lock_skip: blk=%0d nres=%0d want 6 1", write_block_o, nreserved_o);
        end
    endtask

    task automatic test_unlock_free_wrap();
        int guard = 0;
        do_lock(5, 1'b0);
        do begin
            do_done();
            guard++;
        end while (exp_blk != 6 && guard < 600);
        do_free(5);
        guard = 0;
        do begin
            do_done();
            guard++;
        end while (exp_blk != 5 && guard < 600);
        total++;
        if (write_block_o !== 9'd5 || nreserved_o !== 10'd0) begin
            bad++;
            $display("FAIL free_reissue: blk=%0d nres=%0d want 5 0", write_block_o, nreserved_o);
        end
    endtask

    task automatic test_lock_all();
        int highs = 0;
        int cyc   = 0;
        for (int a = 0; a < 512; a++) do_lock(a, 1'b1);
        m_push(exp_blk);
        write_done_i = 1'b1;
        tick();
        write_done_i = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (i == 20) write_done_i = 1'b1;
            if (i == 21) write_done_i = 1'b0;
            if (write_ready_o === 1'b1) highs++;
        end
        total++;
        if (highs != 0) begin
            bad++;
            $display("FAIL all_locked_ready: high_cycles=%0d want 0", highs);
        end
        do_lock(200, 1'b0);
        do_free(200);
        while (write_ready_o !== 1'b1 && cyc < 600) begin
            tick();
            cyc++;
        end
        exp_blk = 200;
        total++;
        if (write_ready_o !== 1'b1 || write_block_o !== 9'd200) begin
            bad++;
            $display("FAIL unlock_200: rdy=%0b blk=%0d want 1 200", write_ready_o, write_block_o);
        end
        do_hist(1);
        for (int a = 0; a < 512; a++) begin
            if (a != 200) begin
                do_lock(a, 1'b0);
                do_free(a);
            end
        end
    endtask

    task automatic test_free_hold();
        int acks = 0;
        int a;
        a = (exp_blk + 100) % 512;
        do_lock(a, 1'b1);
        do_lock(a, 1'b0);
        free_address_i = 9'(a);
        free_strobe_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (free_ack_o === 1'b1) acks++;
        end
        free_strobe_i = 1'b0;
        tick();
        if (free_ack_o === 1'b1) acks++;
        mR[a] = 1'b0;
        total++;
        if (acks != 1 || nreserved_o !== 10'(m_count())) begin
            bad++;
            $display("FAIL free_hold: acks=%0d nres=%0d want 1 %0d", acks, nreserved_o, m_count());
        end
    endtask

    task automatic test_same_cycle_lock();
        int guard = 0;
        while (exp_blk != 6 && guard < 600) begin
            do_done();
            guard++;
        end
        m_push(exp_blk);
        write_done_i = 1'b1;
        tick();
        write_done_i   = 1'b0;
        lock_address_i = 9'd7;
        lock_i         = 1'b1;
        lock_strobe_i  = 1'b1;
        tick();
        lock_strobe_i  = 1'b0;
        mL[7] = 1'b1;
        mR[7] = 1'b1;
        total++;
        if (write_ready_o !== 1'b0 || lock_ack_o !== 1'b1) begin
            bad++;
            $display("FAIL cand_lock_reject: rdy=%0b lack=%0b want 0 1", write_ready_o, lock_ack_o);
        end
        tick();
        exp_blk = 8;
        total++;
        if (write_ready_o !== 1'b1 || write_block_o !== 9'd8) begin
            bad++;
            $display("FAIL cand_lock_land: rdy=%0b blk=%0d want 1 8", write_ready_o, write_block_o);
        end
        do_lock(7, 1'b0);
        do_free(7);
    endtask

    task automatic test_hist_back_to_back();
        nprev_i       = 9'd0;
        history_req_i = 1'b1;
        tick();
        tick();
        total++;
        if (history_ack_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first_ack: ack=%0b want 1", history_ack_o);
        end
        check_hist(0, "b2b_first");
        tick();
        tick();
        total++;
        if (history_ack_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap: ack=%0b want 0", history_ack_o);
        end
        tick();
        history_req_i = 1'b0;
        total++;
        if (history_ack_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second_ack: ack=%0b want 1", history_ack_o);
        end
        check_hist(0, "b2b_second");
        tick();
    endtask

    task automatic test_reset_midscan();
        for (int i = 1; i <= 20; i++) do_lock((exp_blk + i) % 512, 1'b1);
        write_done_i = 1'b1;
        tick();
        write_done_i = 1'b0;
        tick();
        tick();
        #2 rst_n_i = 1'b0;
        #1;
        total++;
        if (write_block_o !== 9'd0 || write_ready_o !== 1'b1 || history_ack_o !== 1'b0 ||
            block_o !== 10'd0 || lock_ack_o !== 1'b0 || free_ack_o !== 1'b0 ||
            nreserved_o !== 10'd0) begin
            bad++;
            $display("FAIL async_reset: blk=%0d rdy=%0b hack=%0b block=%h lack=%0b fack=%0b nres=%0d want 0 1 0 0 0 0 0",
                     write_block_o, write_ready_o, history_ack_o, block_o,
                     lock_ack_o, free_ack_o, nreserved_o);
        end
        m_reset();
        #2 rst_n_i = 1'b1;
        tick();
        do_hist(0);
        do_done();
    endtask

    task automatic test_random();
        int op;
        int a;
        for (int i = 0; i < 120; i++) begin
            op = int'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 31));
            case (op)
                0: if (m_next(exp_blk) > 0) do_done();
                1: do_lock(a, 1'($urandom_range(0, 1)));
                2: do_free(a);
                default: begin
                    a = int'($urandom_range(0, hist.size() + 2));
                    if (a > 511) a = 511;
                    do_hist(a);
                end
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lock_skip();
        test_unlock_free_wrap();
        test_lock_all();
        test_free_hold();
        test_same_cycle_lock();
        test_hist_back_to_back();
        test_reset_midscan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ddaeval_block_manager.md
# ddaeval_block_manager

Bookkeeping stage directly upstream of the soft-trigger handler: tracks which digitizer block the writer fills next, keeps a ring history of completed blocks, and services history lookups and lock/unlock/free requests. It answers `history_req`/`lock_strobe`/`free_strobe` from the readout handler and steers the digitizer writer past blocks held for readout. It is the single owner of per-block reservation state in the DDA-eval readout path.

## Interface
- `NBLK_LOG2`, 9: log2 of block count; 512 blocks, addresses 9 bits.
- `clk_i` in 1: system clock.
- `rst_n_i` in 1: **reset is asynchronous and active-low**; single clock domain `clk_i`.
- `write_done_i` in 1: one-cycle pulse; writer finished block `write_block_o`.
- `write_block_o` out 9: block the writer must fill now.
- `write_ready_o` out 1: `write_block_o` is valid and unreserved.
- `history_req_i` in 1: level; held until `history_ack_o`.
- `nprev_i` in 9: history depth; 0 = most recently completed block.
- `history_ack_o` out 1: one-cycle pulse.
- `block_o` out 10: {invalid, address}; valid only while `history_ack_o` is high.
- `lock_strobe_i` in 1: one-cycle pulse.
- `lock_i` in 1: 1 = lock, 0 = unlock; sampled with the strobe.
- `lock_address_i` in 9: target block.
- `lock_ack_o` out 1: one-cycle pulse.
- `free_strobe_i` in 1: level; held until `free_ack_o`.
- `free_address_i` in 9: block to release.
- `free_ack_o` out 1: one-cycle pulse.
- `nreserved_o` out 10: count of blocks with R or L set.

## Operation
- Per-block state: L (locked), R (reserved), both 0 at reset. Lock sets L and R. Unlock clears L only. Free clears R only. A block is usable by the writer iff L=0 and R=0.
- History ring: 2^NBLK_LOG2 entries, one RAM write per `write_done_i`, storing `write_block_o`; 10-bit `nwritten` counter saturates at 512.
- Writer FSM:
  - States: SCAN, READY.
  - Reset lands in READY with block 0.
  - On `write_done_i` in READY: go to SCAN with candidate = block+1, wrapping 511→0.
  - SCAN tests one candidate per cycle. If usable: go to READY with `write_block_o` = candidate. Otherwise advance the candidate.
  - After 512 consecutive rejects, stay in SCAN, restarting from the same start point, until a block becomes usable.
  - `write_ready_o` is high only in READY.
- History FSM:
  - States: IDLE, READ, ACK.
  - IDLE → READ on `history_req_i`. Ring address = wr_ptr − 1 − `nprev_i`, mod 512.
  - READ → ACK after one cycle of RAM read.
  - ACK pulses `history_ack_o` and returns to IDLE.
  - `block_o[9]` = 1 when `nprev_i` ≥ `nwritten`; the address field is then don't-care.
- Lock: processed in the strobe cycle; ack registered.
- Free: processed when `free_strobe_i && !free_ack_o`, so a held strobe is serviced once.
- Write R/L updates for a read-modify-write in the same cycle apply lock first, then free; different addresses update independently.
- `nreserved_o` tracks the population of (L|R) incrementally: ±1 per transition, never recomputed from scratch.

## Timing
- Reset values: `write_block_o`=0, `write_ready_o`=1, all acks 0, `block_o`=0, `nreserved_o`=0, `nwritten`=0, wr_ptr=0.
- History: req sampled at edge N; `history_ack_o` high in cycle N+2. The requester drops req in the ack cycle. A req still high the cycle after ack starts a new lookup.
- Lock: strobe at N → `lock_ack_o` at N+1; the L/R bits are updated at edge N+1.
- Free: strobe seen at N → `free_ack_o` at N+1.
- Scan: `write_done_i` at N. With the next block usable, `write_ready_o` returns high at N+2.
- A `write_done_i` arriving while in SCAN is a protocol error: ignored, with no RAM write.
- Lock strobe targeting the current SCAN candidate in the same cycle: the candidate is rejected.
- Locking the block currently in READY is allowed. The writer keeps that block until its next `write_done_i`; the block is not reissued until unlocked and freed.
- Async reset mid-operation: all FSMs and state bits clear immediately; pending acks are lost, and requesters reissue.

## Structure
- A shared package `ddaeval_blk_pkg` holds:
  - `NBLK_LOG2`
  - the block address type
  - the writer/history state encodings
- The history ring is sub-module `ddaeval_block_history_ram`: 512×9 simple dual-port memory with registered read. The L/R bitmaps are flops in the top.

## Test plan
- Reset, then 3 `write_done_i` pulses. Expect `write_block_o` 1, 2, 3. History req with nprev=2 → `block_o`=0x000; with nprev=3 → `block_o[9]`=1.
- Lock block 5 while the writer is at 3, then `write_done_i` twice. Expect blocks 4, then 6 (5 skipped); `nreserved_o`=1.
- Unlock 5 without free, and wrap the writer past 5: still skipped. Then free 5 and wrap again: 5 is issued and `nreserved_o`=0.
- Lock all 512 blocks, then `write_done_i`: `write_ready_o` stays 0. Unlock and free block 200 → READY with `write_block_o`=200.
- Hold `free_strobe_i` for 4 cycles: exactly one `free_ack_o` and one R clear.
- Same-cycle lock of candidate 7 during SCAN from 6: writer lands on 8. Assert `rst_n_i` mid-scan: all outputs return to reset values asynchronously.
